// File: rtl/acc_sched_pkg.sv
// Shared definitions for the accumulator-sharing scheduler.
//   - sched_state_e : scheduler FSM states
//   - DEF_DATA_W    : default beat/total width
//   - DEF_MAX_BEATS : default per-transaction beat limit
//   - id_width()    : requester ID width for a given requester count
package acc_sched_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_MAX_BEATS = 256;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StSettle,
        StRespond
    } sched_state_e;

    // Never returns 0 so a single-entry range still gets a 1-bit field.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one search.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index for this search
//   grant : first set bit of req at or above ptr, wrapping to index 0
//   any   : at least one request bit is set
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any
);

    logic            any_hi;
    logic [ID_W-1:0] grant_hi;
    logic [ID_W-1:0] grant_all;

    // Two searches: bits at or above ptr first, then the whole vector for
    // the wrap case. Descending loops leave the lowest matching index last.
    always_comb begin
        any_hi    = 1'b0;
        any       = 1'b0;
        grant_hi  = '0;
        grant_all = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                any       = 1'b1;
                grant_all = ID_W'(i);
                if (i >= int'(ptr)) begin
                    any_hi   = 1'b1;
                    grant_hi = ID_W'(i);
                end
            end
        end
        grant = any_hi ? grant_hi : grant_all;
    end

endmodule

// File: rtl/acc_share_scheduler.sv
// Shares one accumulator datapath between N_REQ requesters, one whole
// transaction at a time, granted round-robin.
//   i_CLK, i_RESET_N         : clock, async active-low reset
//   i_REQ/i_DATA/i_LAST      : per-requester beat valid, data, last marker
//   o_READY                  : per-requester beat accept
//   o_ACC_ENABLE/o_ACC_DATA  : beat into the accumulator (zero latency)
//   o_ACC_CLEAR              : one-cycle synchronous clear of the accumulator
//   i_ACC_TOTAL              : registered accumulator total
//   o_RESULT_*               : captured total, owner, truncation flag, valid
//   i_RESULT_READY           : result consumer handshake
//   o_BUSY                   : scheduler not idle
module acc_share_scheduler
    import acc_sched_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BEATS = DEF_MAX_BEATS,
    parameter int unsigned ID_W      = id_width(N_REQ)
) (
    input  logic                    i_CLK,
    input  logic                    i_RESET_N,
    input  logic [N_REQ-1:0]        i_REQ,
    input  logic [N_REQ*DATA_W-1:0] i_DATA,
    input  logic [N_REQ-1:0]        i_LAST,
    output logic [N_REQ-1:0]        o_READY,
    output logic                    o_ACC_ENABLE,
    output logic [DATA_W-1:0]       o_ACC_DATA,
    output logic                    o_ACC_CLEAR,
    input  logic [DATA_W-1:0]       i_ACC_TOTAL,
    output logic                    o_RESULT_VALID,
    output logic [DATA_W-1:0]       o_RESULT,
    output logic [ID_W-1:0]         o_RESULT_ID,
    output logic                    o_RESULT_TRUNC,
    input  logic                    i_RESULT_READY,
    output logic                    o_BUSY
);

    localparam int unsigned CNT_W = id_width(MAX_BEATS);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trunc_q, trunc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [ID_W-1:0]   result_id_q, result_id_d;
    logic              result_trunc_q, result_trunc_d;
    logic              result_valid_q, result_valid_d;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic [DATA_W-1:0] data_arr [N_REQ];
    logic              sel_req;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        for (int k = 0; k < int'(N_REQ); k++) begin
            data_arr[k] = i_DATA[k*DATA_W +: DATA_W];
        end
    end

    assign sel_req  = i_REQ[grant_q];
    assign sel_last = i_LAST[grant_q];
    assign sel_data = data_arr[grant_q];

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req   (i_REQ),
        .ptr   (ptr_q),
        .grant (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        trunc_d        = trunc_q;
        result_d       = result_q;
        result_id_d    = result_id_q;
        result_trunc_d = result_trunc_q;
        result_valid_d = result_valid_q;
        o_READY        = '0;
        o_ACC_ENABLE   = 1'b0;
        o_ACC_DATA     = '0;
        o_ACC_CLEAR    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = StClear;
                end
            end
            StClear: begin
                o_ACC_CLEAR = 1'b1;
                cnt_d       = '0;
                state_d     = StAccum;
            end
            StAccum: begin
                o_READY[grant_q] = 1'b1;
                if (sel_req) begin
                    o_ACC_ENABLE = 1'b1;
                    o_ACC_DATA   = sel_data;
                    cnt_d        = cnt_q + CNT_W'(1);
                    // i_LAST wins over the limit when both hit on one beat.
                    if (sel_last || (cnt_q == CNT_W'(MAX_BEATS - 1))) begin
                        trunc_d = ~sel_last;
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                // The last beat is now in i_ACC_TOTAL.
                result_d       = i_ACC_TOTAL;
                result_id_d    = grant_q;
                result_trunc_d = trunc_q;
                result_valid_d = 1'b1;
                state_d        = StRespond;
            end
            StRespond: begin
                if (i_RESULT_READY) begin
                    result_valid_d = 1'b0;
                    ptr_d   = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q        <= StIdle;
            grant_q        <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            trunc_q        <= 1'b0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_trunc_q <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            trunc_q        <= trunc_d;
            result_q       <= result_d;
            result_id_q    <= result_id_d;
            result_trunc_q <= result_trunc_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign o_RESULT_VALID = result_valid_q;
    assign o_RESULT       = result_q;
    assign o_RESULT_ID    = result_id_q;
    assign o_RESULT_TRUNC = result_trunc_q;
    assign o_BUSY         = (state_q != StIdle);

endmodule

// File: tb/tb_acc_share_scheduler.sv
// Bench for acc_share_scheduler: four requesters, beat limit 4, with a
// behavioural accumulator and a transaction-level round-robin model.
module tb_acc_share_scheduler;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    typedef struct {
        logic [31:0] data;
        bit          last;
        int          gap;
    } beat_t;

    typedef struct {
        logic [31:0] val;
        int          id;
        bit          trunc;
    } res_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N-1:0]    last;
    logic [N-1:0]    o_READY;
    logic            o_ACC_ENABLE;
    logic [DW-1:0]   o_ACC_DATA;
    logic            o_ACC_CLEAR;
    logic [DW-1:0]   acc_total = '0;
    logic            o_RESULT_VALID;
    logic [DW-1:0]   o_RESULT;
    logic [1:0]      o_RESULT_ID;
    logic            o_RESULT_TRUNC;
    logic            res_ready;
    logic            o_BUSY;

    beat_t bq[N][$];
    res_t  expq[$];
    int    gap_left[N];
    int    ptr_m;
    int    tests = 0;
    int    fails = 0;
    int    clr_cnt, en_cnt, beats_acc, first_valid, steps_since_load;
    int    rdy_delay, wcnt;
    bit    in_resp, held;
    logic [31:0] hold_val;
    logic [1:0]  hold_id;
    logic        hold_trunc;

    acc_share_scheduler #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BEATS (MAXB)
    ) dut (
        .i_CLK          (clk),
        .i_RESET_N      (rst_n),
        .i_REQ          (req),
        .i_DATA         (data),
        .i_LAST         (last),
        .o_READY        (o_READY),
        .o_ACC_ENABLE   (o_ACC_ENABLE),
        .o_ACC_DATA     (o_ACC_DATA),
        .o_ACC_CLEAR    (o_ACC_CLEAR),
        .i_ACC_TOTAL    (acc_total),
        .o_RESULT_VALID (o_RESULT_VALID),
        .o_RESULT       (o_RESULT),
        .o_RESULT_ID    (o_RESULT_ID),
        .o_RESULT_TRUNC (o_RESULT_TRUNC),
        .i_RESULT_READY (res_ready),
        .o_BUSY         (o_BUSY)
    );

    always #5 clk = ~clk;

    // The shared accumulator: synchronous clear, registered total.
    always @(posedge clk) begin
        if (o_ACC_CLEAR) acc_total <= '0;
        else if (o_ACC_ENABLE) acc_total <= acc_total + o_ACC_DATA;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d, input bit l, input int gap);
        beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = gap;
        bq[k].push_back(b);
    endtask

    function automatic bit any_pending();
        for (int k = 0; k < N; k++) if (bq[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Transaction-level model: serve nonempty requesters round-robin; each
    // transaction takes beats up to the first last or MAXB beats.
    task automatic model_batch();
        beat_t cq[N][$];
        for (int k = 0; k < N; k++) cq[k] = bq[k];
        while (1) begin
            int g = -1;
            logic [31:0] sum = 0;
            int n = 0;
            bit seen_last = 0;
            res_t r;
            for (int i = 0; i < N; i++) begin
                int c = (ptr_m + i) % N;
                if (g < 0 && cq[c].size() > 0) g = c;
            end
            if (g < 0) break;
            while (n < MAXB && !seen_last && cq[g].size() > 0) begin
                beat_t b = cq[g].pop_front();
                sum += b.data;
                seen_last = b.last;
                n++;
            end
            r.val = sum;
            r.id = g;
            r.trunc = !seen_last;
            expq.push_back(r);
            ptr_m = (g + 1) % N;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (gap_left[k] > 0) begin
                req[k] = 1'b0;
                last[k] = 1'b0;
                data[k*DW +: DW] = $urandom;
                gap_left[k]--;
            end else if (bq[k].size() > 0) begin
                req[k] = 1'b1;
                last[k] = bq[k][0].last;
                data[k*DW +: DW] = bq[k][0].data;
            end else begin
                req[k] = 1'b0;
                last[k] = 1'b0;
                data[k*DW +: DW] = $urandom;
            end
        end
        if (o_RESULT_VALID) begin
            if (!in_resp) begin
                in_resp = 1'b1;
                wcnt = rdy_delay;
            end
            if (wcnt == 0) res_ready = 1'b1;
            else begin
                res_ready = 1'b0;
                wcnt--;
            end
        end else begin
            in_resp = 1'b0;
            res_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock: check at the falling edge, advance and drive after the rising edge.
    task automatic step();
        logic [N-1:0] acc;
        int a;
        @(negedge clk);
        acc = req & o_READY;
        check("ready_onehot0", 32'($onehot0(o_READY)), 32'd1);
        if (acc != 0) begin
            a = 0;
            for (int k = N - 1; k >= 0; k--) if (acc[k]) a = k;
            check("acc_enable_on_beat", 32'(o_ACC_ENABLE), 32'd1);
            check("acc_data_on_beat", o_ACC_DATA, bq[a][0].data);
            beats_acc++;
            en_cnt++;
        end else begin
            check("acc_enable_idle", 32'(o_ACC_ENABLE), 32'd0);
            check("acc_data_idle", o_ACC_DATA, 32'd0);
        end
        if (o_ACC_CLEAR) clr_cnt++;
        if (o_RESULT_VALID) begin
            if (first_valid < 0) first_valid = steps_since_load;
            check("busy_in_respond", 32'(o_BUSY), 32'd1);
            check("no_grant_in_respond", 32'({o_READY, o_ACC_CLEAR}), 32'd0);
            if (held) begin
                check("hold_result", o_RESULT, hold_val);
                check("hold_id", 32'(o_RESULT_ID), 32'(hold_id));
                check("hold_trunc", 32'(o_RESULT_TRUNC), 32'(hold_trunc));
            end
            if (res_ready) begin
                check("result_expected", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    res_t r = expq.pop_front();
                    check("result_value", o_RESULT, r.val);
                    check("result_id", 32'(o_RESULT_ID), 32'(r.id));
                    check("result_trunc", 32'(o_RESULT_TRUNC), 32'(r.trunc));
                end
                held = 1'b0;
            end else begin
                held = 1'b1;
                hold_val = o_RESULT;
                hold_id = o_RESULT_ID;
                hold_trunc = o_RESULT_TRUNC;
            end
        end else begin
            held = 1'b0;
        end
        steps_since_load++;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                void'(bq[k].pop_front());
                gap_left[k] = (bq[k].size() > 0) ? bq[k][0].gap : 0;
            end
        end
        drive();
    endtask

    task automatic begin_batch();
        model_batch();
        first_valid = -1;
        steps_since_load = 0;
        clr_cnt = 0;
        en_cnt = 0;
        beats_acc = 0;
        drive();
    endtask

    task automatic run_drain(input string tag, input int budget);
        int n = 0;
        while ((expq.size() > 0 || any_pending() || o_RESULT_VALID) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(o_READY), 32'd0);
        check({tag, "_acc_enable"}, 32'(o_ACC_ENABLE), 32'd0);
        check({tag, "_acc_data"}, o_ACC_DATA, 32'd0);
        check({tag, "_acc_clear"}, 32'(o_ACC_CLEAR), 32'd0);
        check({tag, "_valid"}, 32'(o_RESULT_VALID), 32'd0);
        check({tag, "_result"}, o_RESULT, 32'd0);
        check({tag, "_id"}, 32'(o_RESULT_ID), 32'd0);
        check({tag, "_trunc"}, 32'(o_RESULT_TRUNC), 32'd0);
        check({tag, "_busy"}, 32'(o_BUSY), 32'd0);
    endtask

    task automatic flush();
        for (int k = 0; k < N; k++) begin
            bq[k].delete();
            gap_left[k] = 0;
        end
        expq.delete();
        ptr_m = 0;
        held = 1'b0;
        in_resp = 1'b0;
        req = '0;
        last = '0;
        data = '0;
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rdy_delay = 0;
        wcnt = 0;
        flush();
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();

        // 5 + 7 + 9 with last on 9; result held 3 cycles.
        push(0, 32'd5, 0, 0);
        push(0, 32'd7, 0, 0);
        push(0, 32'd9, 1, 0);
        rdy_delay = 3;
        begin_batch();
        run_drain("single", 40);
        check("single_clear_pulses", 32'(clr_cnt), 32'd1);
        check("single_enables", 32'(en_cnt), 32'd3);

        // Contention between 1 and 3: 1 first, then 3.
        push(1, 32'h4000_0000, 1, 0);
        push(3, 32'd1, 1, 0);
        rdy_delay = 0;
        begin_batch();
        run_drain("contention", 40);
        check("contention_clears", 32'(clr_cnt), 32'd2);

        // Six ones on requester 2: limit ends the first four, last ends the other two.
        for (int j = 0; j < 6; j++) push(2, 32'd1, (j == 5), 0);
        begin_batch();
        run_drain("truncate", 60);

        // Last on exactly the limit beat: not truncated.
        for (int j = 0; j < 4; j++) push(1, 32'(j + 1), (j == 3), 0);
        begin_batch();
        run_drain("limit_last", 40);

        // Three-cycle gap before the second beat.
        push(0, 32'd11, 0, 0);
        push(0, 32'd22, 0, 3);
        push(0, 32'd33, 1, 0);
        begin_batch();
        run_drain("stall", 40);
        check("stall_enables", 32'(en_cnt), 32'd3);

        // Result held back five cycles while another requester waits.
        push(0, 32'd100, 1, 0);
        push(3, 32'd200, 1, 0);
        rdy_delay = 5;
        begin_batch();
        run_drain("backpressure", 60);
        rdy_delay = 0;

        // Total wraps modulo 2^32.
        push(1, 32'hFFFF_FFFF, 0, 0);
        push(1, 32'd2, 1, 0);
        begin_batch();
        run_drain("wrap", 40);

        // Reset after two beats of an open transaction.
        for (int j = 0; j < 4; j++) push(0, 32'(j + 3), 0, 0);
        begin_batch();
        begin
            int n = 0;
            while (beats_acc < 2 && n < 20) begin
                step();
                n++;
            end
            check("reset_reached_two_beats", 32'(beats_acc), 32'd2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(0, 32'd10, 1, 0);
        begin_batch();
        run_drain("after_reset", 40);
        check("min_latency_to_valid", 32'(first_valid), 32'd4);

        // Random batches: each requester gets up to two transactions.
        for (int b = 0; b < 30; b++) begin
            for (int k = 0; k < N; k++) begin
                int ntx = $urandom_range(0, 2);
                for (int t = 0; t < ntx; t++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        for (int j = 0; j < MAXB; j++)
                            push(k, $urandom, 0, (j == 0) ? 0 : $urandom_range(0, 2));
                    end else begin
                        int len = $urandom_range(1, 7);
                        for (int j = 0; j < len; j++)
                            push(k, $urandom, (j == len - 1),
                                 (j % MAXB == 0) ? 0 : $urandom_range(0, 2));
                    end
                end
            end
            rdy_delay = $urandom_range(0, 3);
            begin_batch();
            run_drain("random", 400);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
